// File: rtl/id_stage_if.sv
`default_nettype none
// =============================================================================
// Module   : id_stage_if
// Brief    : IF/ID-side, regfile, forwarding and EX-side signals of id_stage.
// Revision : 1.0
// =============================================================================
interface id_stage_if #(
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) ();
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       pc_i;
   logic [31:0]       inst_i;
   logic [RA_W-1:0]   reg1_addr_o;
   logic [RA_W-1:0]   reg2_addr_o;
   logic              reg1_read_o;
   logic              reg2_read_o;
   logic [XLEN-1:0]   reg1_data_i;
   logic [XLEN-1:0]   reg2_data_i;
   logic              ex_wreg_i;
   logic [RA_W-1:0]   ex_waddr_i;
   logic [XLEN-1:0]   ex_wdata_i;
   logic              ex_is_load_i;
   logic              mem_wreg_i;
   logic [RA_W-1:0]   mem_waddr_i;
   logic [XLEN-1:0]   mem_wdata_i;
   logic              flush_i;
   logic              out_valid;
   logic              out_ready;
   logic [2:0]        alusel_o;
   logic [7:0]        aluop_o;
   logic [XLEN-1:0]   reg1_data_o;
   logic [XLEN-1:0]   reg2_data_o;
   logic [RA_W-1:0]   waddr_o;
   logic              wreg_o;
   logic [31:0]       pc_o;
   logic              inst_invalid_o;
   logic [CNT_W-1:0]  stall_cnt_o;

   modport slave (
      input  in_valid, pc_i, inst_i, reg1_data_i, reg2_data_i,
             ex_wreg_i, ex_waddr_i, ex_wdata_i, ex_is_load_i,
             mem_wreg_i, mem_waddr_i, mem_wdata_i, flush_i, out_ready,
      output in_ready, reg1_addr_o, reg2_addr_o, reg1_read_o, reg2_read_o,
             out_valid, alusel_o, aluop_o, reg1_data_o, reg2_data_o,
             waddr_o, wreg_o, pc_o, inst_invalid_o, stall_cnt_o
   );

   modport master (
      output in_valid, pc_i, inst_i, reg1_data_i, reg2_data_i,
             ex_wreg_i, ex_waddr_i, ex_wdata_i, ex_is_load_i,
             mem_wreg_i, mem_waddr_i, mem_wdata_i, flush_i, out_ready,
      input  in_ready, reg1_addr_o, reg2_addr_o, reg1_read_o, reg2_read_o,
             out_valid, alusel_o, aluop_o, reg1_data_o, reg2_data_o,
             waddr_o, wreg_o, pc_o, inst_invalid_o, stall_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// =============================================================================
// Module   : id_stage
// Brief    : Logic-subset decoder with ID/EX register, EX/MEM forwarding,
//            load-use interlock and valid/ready handshakes.
// Revision : 1.0
// =============================================================================
module id_stage #(
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input wire clk,
   input wire rst,
   id_stage_if.slave io
);
   localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
   localparam logic [5:0] c_OP_ANDI    = 6'b001100;
   localparam logic [5:0] c_OP_ORI     = 6'b001101;
   localparam logic [5:0] c_OP_XORI    = 6'b001110;
   localparam logic [5:0] c_OP_LUI     = 6'b001111;
   localparam logic [5:0] c_FN_AND     = 6'b100100;
   localparam logic [5:0] c_FN_OR      = 6'b100101;
   localparam logic [5:0] c_FN_XOR     = 6'b100110;
   localparam logic [5:0] c_FN_NOR     = 6'b100111;
   localparam logic [2:0] c_SEL_NOP    = 3'b000;
   localparam logic [2:0] c_SEL_LOGIC  = 3'b001;
   localparam logic [7:0] c_ALU_NOP    = 8'b00000000;
   localparam logic [7:0] c_ALU_AND    = 8'b00100100;
   localparam logic [7:0] c_ALU_OR     = 8'b00100101;
   localparam logic [7:0] c_ALU_XOR    = 8'b00100110;
   localparam logic [7:0] c_ALU_NOR    = 8'b00100111;

   logic [5:0]       w_opcode, w_funct;
   logic [RA_W-1:0]  w_rs, w_rt, w_rd;
   logic [15:0]      w_imm16;
   logic [XLEN-1:0]  w_imm;
   logic [2:0]       w_alusel;
   logic [7:0]       w_aluop;
   logic [RA_W-1:0]  w_waddr;
   logic             w_wreg, w_re1, w_re2, w_invalid;
   logic [XLEN-1:0]  w_op1, w_op2;
   logic             w_hazard, w_load_en;

   logic             r_out_valid;
   logic [2:0]       r_alusel;
   logic [7:0]       r_aluop;
   logic [XLEN-1:0]  r_reg1, r_reg2;
   logic [RA_W-1:0]  r_waddr;
   logic             r_wreg, r_invalid;
   logic [31:0]      r_pc;
   logic [CNT_W-1:0] r_stall_cnt;

   assign w_opcode = io.inst_i[31:26];
   assign w_rs     = RA_W'(io.inst_i[25:21]);
   assign w_rt     = RA_W'(io.inst_i[20:16]);
   assign w_rd     = RA_W'(io.inst_i[15:11]);
   assign w_funct  = io.inst_i[5:0];
   assign w_imm16  = io.inst_i[15:0];

   always_comb begin
      w_alusel  = c_SEL_NOP;
      w_aluop   = c_ALU_NOP;
      w_waddr   = '0;
      w_wreg    = 1'b0;
      w_re1     = 1'b0;
      w_re2     = 1'b0;
      w_imm     = XLEN'(w_imm16);
      w_invalid = 1'b1;
      case (w_opcode)
         c_OP_ORI, c_OP_ANDI, c_OP_XORI, c_OP_LUI: begin
            w_alusel  = c_SEL_LOGIC;
            w_waddr   = w_rt;
            w_wreg    = 1'b1;
            w_re1     = 1'b1;
            w_invalid = 1'b0;
            case (w_opcode)
               c_OP_ANDI: w_aluop = c_ALU_AND;
               c_OP_XORI: w_aluop = c_ALU_XOR;
               default:   w_aluop = c_ALU_OR;
            endcase
            if (w_opcode == c_OP_LUI)
               w_imm = XLEN'({w_imm16, 16'h0000});
         end
         c_OP_SPECIAL: begin
            if (w_funct == c_FN_AND || w_funct == c_FN_OR ||
                w_funct == c_FN_XOR || w_funct == c_FN_NOR) begin
               w_alusel  = c_SEL_LOGIC;
               w_waddr   = w_rd;
               w_wreg    = 1'b1;
               w_re1     = 1'b1;
               w_re2     = 1'b1;
               w_invalid = 1'b0;
               case (w_funct)
                  c_FN_AND: w_aluop = c_ALU_AND;
                  c_FN_OR:  w_aluop = c_ALU_OR;
                  c_FN_XOR: w_aluop = c_ALU_XOR;
                  default:  w_aluop = c_ALU_NOR;
               endcase
            end
         end
         default: ;
      endcase
   end

   // r0 is hardwired, so it is never a forwarding target
   function automatic logic [XLEN-1:0] f_operand(
      input logic            re,
      input logic [RA_W-1:0] addr,
      input logic [XLEN-1:0] rf,
      input logic [XLEN-1:0] imm,
      input logic            exw,
      input logic [RA_W-1:0] exa,
      input logic [XLEN-1:0] exd,
      input logic            memw,
      input logic [RA_W-1:0] mema,
      input logic [XLEN-1:0] memd
   );
      if (!re)                          return imm;
      else if (addr == '0)              return '0;
      else if (exw && (exa == addr))    return exd;
      else if (memw && (mema == addr))  return memd;
      else                              return rf;
   endfunction

   assign w_op1 = f_operand(w_re1, w_rs, io.reg1_data_i, w_imm,
                            io.ex_wreg_i, io.ex_waddr_i, io.ex_wdata_i,
                            io.mem_wreg_i, io.mem_waddr_i, io.mem_wdata_i);
   assign w_op2 = f_operand(w_re2, w_rt, io.reg2_data_i, w_imm,
                            io.ex_wreg_i, io.ex_waddr_i, io.ex_wdata_i,
                            io.mem_wreg_i, io.mem_waddr_i, io.mem_wdata_i);

   assign w_hazard  = io.in_valid & io.ex_is_load_i & io.ex_wreg_i &
                      (io.ex_waddr_i != '0) &
                      ((w_re1 & (w_rs == io.ex_waddr_i)) |
                       (w_re2 & (w_rt == io.ex_waddr_i)));
   assign w_load_en = io.out_ready | ~r_out_valid;

   assign io.in_ready    = ~rst & (io.flush_i | (w_load_en & ~w_hazard));
   assign io.reg1_addr_o = w_rs;
   assign io.reg2_addr_o = w_rt;
   assign io.reg1_read_o = w_re1;
   assign io.reg2_read_o = w_re2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_alusel    <= '0;
         r_aluop     <= '0;
         r_reg1      <= '0;
         r_reg2      <= '0;
         r_waddr     <= '0;
         r_wreg      <= 1'b0;
         r_invalid   <= 1'b0;
         r_pc        <= '0;
         r_stall_cnt <= '0;
      end else if (io.flush_i) begin
         r_out_valid <= 1'b0;
      end else if (w_load_en && w_hazard) begin
         r_out_valid <= 1'b0;
         if (r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else if (w_load_en) begin
         r_out_valid <= io.in_valid;
         if (io.in_valid) begin
            r_alusel  <= w_alusel;
            r_aluop   <= w_aluop;
            r_reg1    <= w_op1;
            r_reg2    <= w_op2;
            r_waddr   <= w_waddr;
            r_wreg    <= w_wreg;
            r_invalid <= w_invalid;
            r_pc      <= io.pc_i;
         end
      end
   end

   assign io.out_valid      = r_out_valid;
   assign io.alusel_o       = r_alusel;
   assign io.aluop_o        = r_aluop;
   assign io.reg1_data_o    = r_reg1;
   assign io.reg2_data_o    = r_reg2;
   assign io.waddr_o        = r_waddr;
   assign io.wreg_o         = r_wreg;
   assign io.pc_o           = r_pc;
   assign io.inst_invalid_o = r_invalid;
   assign io.stall_cnt_o    = r_stall_cnt;
endmodule
`default_nettype wire
